// File: rtl/minn_window_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minn_window_sum_pkg
// Purpose  : Shared constants, lane slice types and the window-length clamp
//            helper for the multi-channel sliding-window accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package minn_window_sum_pkg;

    localparam int IN_WIDTH_DEF       = 25;
    localparam int LOG2_MAX_DEPTH_DEF = 9;
    localparam int ACC_WIDTH_DEF      = IN_WIDTH_DEF + LOG2_MAX_DEPTH_DEF;

    localparam int DEPTH   = 2 ** LOG2_MAX_DEPTH_DEF;
    localparam int K_WIDTH = $clog2(LOG2_MAX_DEPTH_DEF + 1);

    // One lane's slice of the packed input bus and of the packed output bus
    typedef logic signed [IN_WIDTH_DEF-1:0]  lane_sample_t;
    typedef logic signed [ACC_WIDTH_DEF-1:0] lane_sum_t;

    // Force a requested log2 window length into the legal [k_min, k_max] range
    function automatic int unsigned clamp_log2_len(input int unsigned k,
                                                   input int unsigned k_min,
                                                   input int unsigned k_max);
        if (k < k_min) begin
            return k_min;
        end
        if (k > k_max) begin
            return k_max;
        end
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/minn_circ_buffer.sv
`default_nettype none
// ============================================================================
// Module   : minn_circ_buffer
// Purpose  : WIDTH x 2^LOG2_DEPTH circular RAM. Writes at an internal pointer
//            that wraps modulo depth; the read port returns the entry located
//            rd_offset_i behind the pointer, combinationally, so the value is
//            the one present before this cycle's write (read-before-write).
// Revision : 1.0 - initial release
// ============================================================================
module minn_circ_buffer
    import minn_window_sum_pkg::*;
#(
    parameter int WIDTH      = 50,
    parameter int LOG2_DEPTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic [LOG2_DEPTH-1:0] rd_offset_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    localparam int c_depth = 2 ** LOG2_DEPTH;

    logic [WIDTH-1:0]      mem_q [c_depth];
    logic [LOG2_DEPTH-1:0] wr_ptr_q;
    logic [LOG2_DEPTH-1:0] w_rd_addr;

    // An offset equal to the full depth wraps to 0 and returns the entry about
    // to be overwritten, which is exactly the oldest sample of a full window.
    assign w_rd_addr = wr_ptr_q - rd_offset_i;
    assign rd_data_o = mem_q[w_rd_addr];

    // Storage array: not reset, stale entries are masked by the consumer
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Write pointer advances once per write and wraps naturally at depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
        end else if (wr_en_i) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/minn_window_sum_mc.sv
`default_nettype none
// ============================================================================
// Module   : minn_window_sum_mc
// Purpose  : Multi-lane sliding-window sum / mean for the Minn timing metric.
//            Window length 2^k is chosen at run time; cfg_load flushes the
//            window, and a sample arriving in the same cycle starts the new one.
// Revision : 1.0 - initial release
// ============================================================================
module minn_window_sum_mc
    import minn_window_sum_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int IN_WIDTH       = 25,
    parameter int LOG2_MAX_DEPTH = 9,
    parameter int LOG2_MIN_DEPTH = 2,
    parameter int ACC_WIDTH      = IN_WIDTH + LOG2_MAX_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_load,
    input  logic [$clog2(LOG2_MAX_DEPTH+1)-1:0]   cfg_log2_len,
    input  logic                                  cfg_mean,
    input  logic                                  in_valid,
    input  logic [NUM_CH*IN_WIDTH-1:0]            in_data,
    output logic                                  out_valid,
    output logic [NUM_CH*ACC_WIDTH-1:0]           out_data,
    output logic [$clog2(LOG2_MAX_DEPTH+1)-1:0]   cur_log2_len,
    output logic                                  filling
);

    localparam int c_k_w    = $clog2(LOG2_MAX_DEPTH + 1);
    localparam int c_fill_w = LOG2_MAX_DEPTH + 1;
    localparam int c_bus_w  = NUM_CH * IN_WIDTH;

    logic [c_k_w-1:0]    k_q;
    logic                mean_q;
    logic [c_fill_w-1:0] fill_q;
    logic                out_valid_q;

    logic [c_k_w-1:0]    w_k;
    logic                w_mean;
    logic [c_fill_w-1:0] w_len;
    logic [c_fill_w-1:0] w_fill_base;
    logic                w_full;
    logic                w_out_hit;
    logic [c_bus_w-1:0]  w_rd_data;

    // Effective configuration and fill state for this cycle: a cfg_load takes
    // effect before any sample accepted in the same cycle.
    always_comb begin
        w_k         = k_q;
        w_mean      = mean_q;
        w_fill_base = fill_q;
        if (cfg_load) begin
            w_k         = c_k_w'(clamp_log2_len(int'(cfg_log2_len),
                                                LOG2_MIN_DEPTH, LOG2_MAX_DEPTH));
            w_mean      = cfg_mean;
            w_fill_base = '0;
        end
        w_len     = c_fill_w'(1) << w_k;
        w_full    = (w_fill_base >= w_len);
        w_out_hit = in_valid && (w_fill_base >= (w_len - c_fill_w'(1)));
    end

    // Config registers, saturating fill counter and output strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= c_k_w'(LOG2_MAX_DEPTH);
            mean_q      <= 1'b0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            k_q         <= w_k;
            mean_q      <= w_mean;
            fill_q      <= (in_valid && !w_full) ? (w_fill_base + c_fill_w'(1)) : w_fill_base;
            out_valid_q <= w_out_hit;
        end
    end

    minn_circ_buffer #(
        .WIDTH      (c_bus_w),
        .LOG2_DEPTH (LOG2_MAX_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (in_valid),
        .wr_data_i   (in_data),
        .rd_offset_i (w_len[LOG2_MAX_DEPTH-1:0]),
        .rd_data_o   (w_rd_data)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic signed [ACC_WIDTH-1:0] acc_q;
        logic signed [ACC_WIDTH-1:0] out_q;
        logic signed [ACC_WIDTH-1:0] w_x;
        logic signed [ACC_WIDTH-1:0] w_old;
        logic signed [ACC_WIDTH-1:0] w_acc_base;
        logic signed [ACC_WIDTH-1:0] acc_d;
        logic signed [ACC_WIDTH-1:0] out_d;
        logic [IN_WIDTH-1:0]         w_in_raw;
        logic [IN_WIDTH-1:0]         w_old_raw;

        // Sign-extend new and oldest samples; oldest only counts once full
        always_comb begin
            w_in_raw   = in_data[c*IN_WIDTH +: IN_WIDTH];
            w_old_raw  = w_rd_data[c*IN_WIDTH +: IN_WIDTH];
            w_x        = {{(ACC_WIDTH-IN_WIDTH){w_in_raw[IN_WIDTH-1]}}, w_in_raw};
            w_old      = w_full ? {{(ACC_WIDTH-IN_WIDTH){w_old_raw[IN_WIDTH-1]}}, w_old_raw}
                                : '0;
            w_acc_base = cfg_load ? '0 : acc_q;
            acc_d      = w_acc_base + w_x - w_old;
            out_d      = w_mean ? (acc_d >>> w_k) : acc_d;
        end

        // Running window sum and held output value for this lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q <= '0;
                out_q <= '0;
            end else begin
                acc_q <= in_valid ? acc_d : w_acc_base;
                if (w_out_hit) begin
                    out_q <= out_d;
                end
            end
        end

        assign out_data[c*ACC_WIDTH +: ACC_WIDTH] = out_q;
    end

    assign out_valid    = out_valid_q;
    assign cur_log2_len = k_q;
    assign filling      = (fill_q < (c_fill_w'(1) << k_q));

endmodule
`default_nettype wire

// File: doc/minn_window_sum_mc.md
Name: minn_window_sum_mc

Overview:
- Multi-channel sliding-window accumulator for the Minn timing-metric datapath.
- NUM_CH lanes share one valid strobe; each lane has its own sliding-window sum.
- Window length L = 2^k is selectable at run time up to 2^LOG2_MAX_DEPTH. The output is the raw window sum or the window mean.
- Sits between the correlator products and the metric/peak detector. A length change flushes the window without a global reset.

Parameters:
- NUM_CH, 2: number of parallel lanes (e.g. I/Q or correlation + energy).
- IN_WIDTH, 25: signed input width per lane.
- LOG2_MAX_DEPTH, 9: log2 of maximum window (512); sets buffer depth.
- LOG2_MIN_DEPTH, 2: smallest legal k.
- ACC_WIDTH, IN_WIDTH+LOG2_MAX_DEPTH: accumulator/sum width; guaranteed no overflow.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_load  in  1  pulse: apply cfg_log2_len and flush window
- cfg_log2_len  in  $clog2(LOG2_MAX_DEPTH+1)  requested k
- cfg_mean  in  1  1 = output mean (sum >>> k), 0 = raw sum; sampled on cfg_load
- in_valid  in  1  sample strobe, all lanes
- in_data  in  NUM_CH*IN_WIDTH  packed signed samples, lane 0 in LSBs
- out_valid  out  1  window full, out_data valid
- out_data  out  NUM_CH*ACC_WIDTH  packed signed sum/mean per lane
- cur_log2_len  out  $clog2(LOG2_MAX_DEPTH+1)  active k
- filling  out  1  window flushed/partially filled

Behaviour:
- Reset is asynchronous, active-high, and clears the following:
  - out_valid=0, out_data=0.
  - accumulators=0, fill count=0, write pointer=0.
  - cur_log2_len=LOG2_MAX_DEPTH, mean mode=0.
  - filling=1.
- Buffer contents are not reset. Reads of stale entries are masked by the fill count.
- Config:
  - cfg_load clamps k into [LOG2_MIN_DEPTH, LOG2_MAX_DEPTH] and registers it with cfg_mean.
  - It zeroes accumulators and the fill count, sets filling=1, and forces out_valid=0 the next cycle.
  - cfg_load with in_valid in the same cycle: the flush applies first, then that sample is accepted as sample 0 of the new window under the new k.
- Per accepted sample x[n], for each lane:
  - acc <= acc + x[n] − x[n−L] once fill ≥ L; otherwise acc <= acc + x[n].
  - Inputs are sign-extended to ACC_WIDTH.
- Latency is 1 cycle. On the cycle after in_valid, out_data = Σ x[n−L+1..n], including the current sample.
- out_valid:
  - Registered; high exactly one cycle per accepted sample with fill ≥ L−1 before that sample, i.e. from the L-th sample onward.
  - Low on cycles without in_valid.
  - out_data holds its last value when out_valid=0.
- Mean mode: out_data = arithmetic right shift of the sum by k (rounds toward −∞), sign-extended to ACC_WIDTH.
- Fill count saturates at L; filling = (fill < L).
- Buffer:
  - Circular, depth 2^LOG2_MAX_DEPTH; the write pointer wraps modulo depth.
  - Read address = wr_ptr − L, modulo depth.
  - The old sample must be available in the same cycle as the write: a read-before-write RAM with the read issued combinationally, or a registered read pre-issued one sample ahead. Either way the 1-cycle output latency is preserved.
- in_valid gaps of any length do not disturb window contents.

Decomposition:
- Package minn_window_sum_pkg:
  - function clamp_log2_len;
  - localparams DEPTH=2**LOG2_MAX_DEPTH and K_WIDTH;
  - typedef for the packed lane-sample and lane-sum slices.
- Sub-module minn_circ_buffer:
  - Generic WIDTH×DEPTH circular RAM with write pointer and offset read port.
  - Instantiated once at NUM_CH*IN_WIDTH width.
- Top holds config registers, fill counter, per-lane accumulators (generate loop) and the output register.

Test Plan:
- Warm-up: reset, default k=9, lane0 = +1 continuous for 600 samples. Required:
  - out_valid first high on the 512th output;
  - out_data lane0 = 512 from then on;
  - filling drops on the same cycle out_valid first rises.
- Reconfig: cfg_load with k=2, mean=0; lane0 inputs 1,2,3,4,5,6 with in_valid in every cycle, including the cfg_load cycle. Required:
  - outputs valid starting at input 4: sums 10, 14, 18;
  - cur_log2_len=2.
- Mean/negative: k=2, mean=1, lane1 = −3,−3,−3,−2. Required: out lane1 = −11>>>2 = −3 (floor).
- Clamp and extremes: cfg_log2_len=0 → cur_log2_len=2; cfg_log2_len=15 → 9. All inputs = −2^24 for 600 samples → sum = −2^33, no wrap.
- Gaps/wrap: k=3, lane0 ramp 0..1999 with random in_valid gaps. Required: every out_valid cycle equals the software sliding sum across buffer pointer wrap; out_valid never high without a prior in_valid.
- Async reset mid-stream: assert rst between clock edges during steady state. Required: out_valid and out_data go to 0 immediately; after release, a fresh 512-sample warm-up occurs.
